// File: rtl/pipe_reg_chain_pkg.sv
// pipe_reg_chain_pkg
//   Shared constants and helpers for the pipe_reg_chain block.
//   - PIPE_RESET_VAL_DEFAULT : default data value loaded on reset/flush
//   - occ_width()            : bits needed to count 0..depth valid stages
package pipe_reg_chain_pkg;

  localparam int PIPE_RESET_VAL_DEFAULT = 0;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// pipe_reg_chain_if
//   Groups the data/control inputs and the observable outputs of a
//   pipe_reg_chain.
//   Ports (signals):
//     in_dat    [WIDTH]  data entering stage 0
//     in_valid           in_dat is meaningful
//     stall              hold every stage this edge
//     flush              invalidate every stage this edge
//     out_dat   [WIDTH]  data of the last stage
//     out_valid          valid bit of the last stage
//     occupancy [OCC_W]  number of valid stages
//   Modports: master drives the inputs, slave is the pipeline itself.
interface pipe_reg_chain_if
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 1
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [WIDTH-1:0] in_dat;
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] out_dat;
  logic             out_valid;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_dat, in_valid, stall, flush,
    input  out_dat, out_valid, occupancy
  );

  modport slave (
    input  in_dat, in_valid, stall, flush,
    output out_dat, out_valid, occupancy
  );

endinterface

// File: rtl/pipe_reg_chain_stage.sv
// pipe_reg_stage
//   One falling-edge pipeline stage: WIDTH data bits plus a valid bit.
//   Priority: RST > flush > hold > load.
//   Ports:
//     CLK      clock (state changes on the falling edge)
//     RST      synchronous active-high reset
//     flush    load RESET_VAL and clear valid
//     hold     keep current contents
//     d_dat    data to load
//     d_valid  valid to load
//     q_dat    registered data
//     q_valid  registered valid
module pipe_reg_stage #(
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             hold,
  input  logic [WIDTH-1:0] d_dat,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_dat,
  output logic             q_valid
);

  // Initialisers give the same power-up state as a reset.
  logic [WIDTH-1:0] dat_q = RESET_VAL;
  logic             vld_q = 1'b0;

  always_ff @(negedge CLK) begin
    if (RST || flush) begin
      dat_q <= RESET_VAL;
      vld_q <= 1'b0;
    end else if (!hold) begin
      dat_q <= d_dat;
      vld_q <= d_valid;
    end
  end

  assign q_dat   = dat_q;
  assign q_valid = vld_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//   DEPTH-stage falling-edge register chain with per-stage valid bits,
//   stall (hold), flush (bubble insertion) and a registered occupancy count.
//   Ports:
//     CLK  clock; every register updates on its falling edge
//     RST  synchronous active-high reset
//     bus  pipe_reg_chain_if.slave (in_dat/in_valid/stall/flush in,
//          out_dat/out_valid/occupancy out; all outputs are registers)
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int               WIDTH     = 2,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL_DEFAULT)
) (
  input logic              CLK,
  input logic              RST,
  pipe_reg_chain_if.slave  bus
);

  localparam int               OCC_W     = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  // Element 0 is the chain input; element i+1 is the output of stage i.
  logic [DEPTH:0][WIDTH-1:0] dat_chain;
  logic [DEPTH:0]            vld_chain;

  assign dat_chain[0] = bus.in_dat;
  assign vld_chain[0] = bus.in_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .CLK     (CLK),
      .RST     (RST),
      .flush   (bus.flush),
      .hold    (bus.stall),
      .d_dat   (dat_chain[i]),
      .d_valid (vld_chain[i]),
      .q_dat   (dat_chain[i+1]),
      .q_valid (vld_chain[i+1])
    );
  end

  logic [OCC_W-1:0] occ_q = '0;

  // One entry enters and at most one leaves per shift, so the count stays
  // in 0..DEPTH without saturation logic.
  always_ff @(negedge CLK) begin
    if (RST || bus.flush) begin
      occ_q <= '0;
    end else if (!bus.stall) begin
      occ_q <= occ_q + OCC_W'(bus.in_valid) - OCC_W'(vld_chain[DEPTH]);
    end
  end

  assert property (@(negedge CLK) occ_q <= DEPTH_OCC);

  assign bus.out_dat   = dat_chain[DEPTH];
  assign bus.out_valid = vld_chain[DEPTH];
  assign bus.occupancy = occ_q;

endmodule
